// File: rtl/bist_lfsr_gen.sv
// Parametrised Fibonacci LFSR pattern generator with a start/complete session FSM.
// Optional MISR response compaction is enabled by defining BIST_MISR_EN.
module bist_lfsr_gen #(
  parameter int              WIDTH = 247,
  parameter logic [WIDTH-1:0] TAPS = (WIDTH'(1) << 246) | (WIDTH'(1) << 164),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(1),
  parameter int              CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             bist_en,
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [CNT_W-1:0] num_pat,
`ifdef BIST_MISR_EN
  input  logic             misr_sel,
  input  logic [WIDTH-1:0] resp_in,
`endif
  output logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] pat_cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: bist_en is a level request held by the controller for the whole
  // session; done answers it and stays high until bist_en drops, so a new
  // session needs bist_en low for at least one cycle. Dropping bist_en while
  // busy aborts the session and freezes value/pat_cnt.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] SEED_RST = (SEED == '0) ? WIDTH'(1) : SEED;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [WIDTH-1:0] seed_q, seed_d;

  logic             fb;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] shift_val;
  logic [CNT_W-1:0] cnt_inc;

  assign fb        = ^(value_q & TAPS);
  assign lfsr_next = {value_q[WIDTH-2:0], fb};
  assign cnt_inc   = cnt_q + CNT_W'(1);

`ifdef BIST_MISR_EN
  assign shift_val = misr_sel ? (lfsr_next ^ resp_in) : lfsr_next;
`else
  assign shift_val = lfsr_next;
`endif

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    seed_d  = seed_q;

    // Zero seeds are replaced by 1 so the register can never lock up.
    if (seed_ld && (state_q == S_IDLE || state_q == S_DONE))
      seed_d = (seed_in == '0) ? WIDTH'(1) : seed_in;

    case (state_q)
      S_IDLE: begin
        if (bist_en) state_d = S_INIT;
      end
      S_INIT: begin
        value_d = seed_q;
        cnt_d   = '0;
        num_d   = num_pat;
        state_d = (num_pat == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (!bist_en) begin
          state_d = S_IDLE;
        end else begin
          value_d = shift_val;
          cnt_d   = cnt_inc;
          if (cnt_inc == num_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!bist_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      value_q <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      seed_q  <= SEED_RST;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      seed_q  <= seed_d;
    end
  end

  assign value     = value_q;
  assign pat_cnt   = cnt_q;
  assign busy      = (state_q == S_INIT) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bist_lfsr_gen.sv
// Self-checking bench for bist_lfsr_gen (WIDTH=4, TAPS=4'b1100) against a
// behavioural LFSR/session model; MISR scenario runs when BIST_MISR_EN is defined.
module tb_bist_lfsr_gen;

  localparam int         W      = 4;
  localparam int         CW     = 5;
  localparam logic [W-1:0] TAPS_M = 4'b1100;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          bist_en;
  logic          seed_ld;
  logic [W-1:0]  seed_in;
  logic [CW-1:0] num_pat;
`ifdef BIST_MISR_EN
  logic          misr_sel;
  logic [W-1:0]  resp_in;
`endif
  logic [W-1:0]  value;
  logic [CW-1:0] pat_cnt;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] model_seed;
  logic [W-1:0] exp_q[$];

  bist_lfsr_gen #(
    .WIDTH(W), .TAPS(TAPS_M), .SEED(4'b0001), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_l(rst_l), .bist_en(bist_en), .seed_ld(seed_ld),
    .seed_in(seed_in), .num_pat(num_pat),
`ifdef BIST_MISR_EN
    .misr_sel(misr_sel), .resp_in(resp_in),
`endif
    .value(value), .pat_cnt(pat_cnt), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Next state: shift left by one, new LSB = parity of the tapped bits.
  function automatic logic [W-1:0] ref_next(input logic [W-1:0] v);
    int ones = 0;
    for (int i = 0; i < W; i++)
      if (v[i] && TAPS_M[i]) ones++;
    return W'((int'(v) * 2 + ones % 2) % (1 << W));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [W-1:0] s);
    seed_ld = 1'b1;
    seed_in = s;
    tick();
    seed_ld = 1'b0;
    model_seed = (s == '0) ? W'(1) : s;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_l = 1'b0;
    bist_en = 1'b1;
    repeat (3) tick();
    n_checks++; if (value !== 4'b0000) begin n_fail++; $display("FAIL reset_value: got %b want 0000", value); end
    n_checks++; if (pat_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", pat_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    bist_en = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    model_seed = 4'b0001;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done); end
    n_checks++; if (value !== 4'b0000) begin n_fail++; $display("FAIL reset_idle_value: got %b want 0000", value); end
  endtask

  task automatic test_short();
    logic [W-1:0] v;
    logic [W-1:0] e;
    exp_q.delete();
    v = model_seed;
    for (int k = 1; k <= 3; k++) begin
      v = ref_next(v);
      exp_q.push_back(v);
    end
    bist_en = 1'b1;
    num_pat = 5'd3;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL short_init_busy: got %b want 1", busy); end
    tick();
    n_checks++; if (value !== model_seed) begin n_fail++; $display("FAIL short_seed: got %b want %b", value, model_seed); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if (value !== e) begin n_fail++; $display("FAIL short_pat%0d: got %b want %b", k, value, e); end
      n_checks++; if (pat_cnt !== CW'(k)) begin n_fail++; $display("FAIL short_cnt%0d: got %0d want %0d", k, pat_cnt, k); end
    end
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL short_done: done=%b busy=%b want 1 0", done, busy); end
    n_checks++; if (value !== 4'b1001) begin n_fail++; $display("FAIL short_final: got %b want 1001", value); end
    repeat (2) tick();
    n_checks++; if (done !== 1'b1 || value !== 4'b1001 || pat_cnt !== 5'd3) begin
      n_fail++; $display("FAIL short_hold: done=%b value=%b cnt=%0d want 1 1001 3", done, value, pat_cnt); end
    bist_en = 1'b0;
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL short_release: done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_max_length();
    logic [W-1:0] v;
    logic seen[16];
    int distinct;
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    v = model_seed;
    bist_en = 1'b1;
    num_pat = 5'd15;
    tick();
    tick();
    for (int k = 1; k <= 15; k++) begin
      tick();
      v = ref_next(v);
      n_checks++; if (value !== v) begin n_fail++; $display("FAIL maxlen_pat%0d: got %b want %b", k, value, v); end
      seen[value] = 1'b1;
    end
    distinct = 0;
    for (int i = 1; i < 16; i++) if (seen[i]) distinct++;
    n_checks++; if (distinct != 15) begin n_fail++; $display("FAIL maxlen_distinct: got %0d want 15", distinct); end
    n_checks++; if (value !== 4'b0001 || pat_cnt !== 5'd15 || done !== 1'b1) begin
      n_fail++; $display("FAIL maxlen_end: value=%b cnt=%0d done=%b want 0001 15 1", value, pat_cnt, done); end
    bist_en = 1'b0;
    tick();
  endtask

  task automatic test_abort_zero_seed();
    bist_en = 1'b1;
    num_pat = 5'd10;
    repeat (4) tick();
    bist_en = 1'b0;
    tick();
    n_checks++; if (value !== 4'b0100 || pat_cnt !== 5'd2) begin
      n_fail++; $display("FAIL abort_hold: value=%b cnt=%0d want 0100 2", value, pat_cnt); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_flags: busy=%b done=%b want 0 0", busy, done); end
    tick();
    n_checks++; if (value !== 4'b0100) begin n_fail++; $display("FAIL abort_idle_hold: got %b want 0100", value); end
    load_seed(4'b0000);
    bist_en = 1'b1;
    num_pat = 5'd4;
    tick();
    tick();
    n_checks++; if (value !== 4'b0001 || pat_cnt !== 5'd0) begin
      n_fail++; $display("FAIL zero_seed_guard: value=%b cnt=%0d want 0001 0", value, pat_cnt); end
    bist_en = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_zero_count();
    load_seed(4'b1011);
    bist_en = 1'b1;
    num_pat = 5'd0;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_init_busy: got %b want 1", busy); end
    tick();
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || pat_cnt !== 5'd0 || value !== 4'b1011) begin
      n_fail++; $display("FAIL zero_done: done=%b busy=%b cnt=%0d value=%b want 1 0 0 1011", done, busy, pat_cnt, value); end
    repeat (2) tick();
    n_checks++; if (done !== 1'b1 || value !== 4'b1011) begin n_fail++; $display("FAIL zero_hold: done=%b value=%b want 1 1011", done, value); end
    bist_en = 1'b0;
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_release: got %b want 0", done); end
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    int n;
    int abort_at;
    bit aborted;
    for (int it = 0; it < 12; it++) begin
      load_seed(($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom_range(0, 15)));
      n = $urandom_range(0, 20);
      abort_at = (n >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
      aborted = 1'b0;
      bist_en = 1'b1;
      num_pat = CW'(n);
      tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_init_busy: got %b want 1", it, busy); end
      tick();
      v = model_seed;
      n_checks++; if (value !== v || pat_cnt !== 5'd0) begin
        n_fail++; $display("FAIL rnd%0d_seed: value=%b cnt=%0d want %b 0", it, value, pat_cnt, v); end
      n_checks++; if (done !== (n == 0) || busy !== (n != 0)) begin
        n_fail++; $display("FAIL rnd%0d_start_flags: done=%b busy=%b n=%0d", it, done, busy, n); end
      for (int k = 1; k <= n; k++) begin
        // Perturbations during RUN that must have no effect.
        num_pat = CW'($urandom_range(0, 31));
        seed_ld = 1'($urandom_range(0, 1));
        seed_in = W'($urandom_range(0, 15));
        if (k - 1 == abort_at) begin
          bist_en = 1'b0;
          tick();
          n_checks++; if (value !== v || pat_cnt !== CW'(k - 1) || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rnd%0d_abort: value=%b cnt=%0d busy=%b done=%b want %b %0d 0 0",
                               it, value, pat_cnt, busy, done, v, k - 1); end
          aborted = 1'b1;
          break;
        end
        tick();
        v = ref_next(v);
        n_checks++; if (value !== v || pat_cnt !== CW'(k)) begin
          n_fail++; $display("FAIL rnd%0d_pat%0d: value=%b cnt=%0d want %b %0d", it, k, value, pat_cnt, v, k); end
        n_checks++; if (done !== (k == n) || busy !== (k != n)) begin
          n_fail++; $display("FAIL rnd%0d_flags%0d: done=%b busy=%b", it, k, done, busy); end
      end
      seed_ld = 1'b0;
      bist_en = 1'b0;
      tick();
      n_checks++; if (done !== 1'b0 || busy !== 1'b0 || value !== v) begin
        n_fail++; $display("FAIL rnd%0d_end: done=%b busy=%b value=%b want 0 0 %b (aborted=%0d)", it, done, busy, value, v, aborted); end
    end
  endtask

  task automatic test_reset_mid_run();
    load_seed(4'b1010);
    bist_en = 1'b1;
    num_pat = 5'd20;
    repeat (4) tick();
    #2;
    rst_l = 1'b0;
    #1;
    n_checks++; if (value !== 4'b0000 || pat_cnt !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: value=%b cnt=%0d busy=%b done=%b want 0000 0 0 0", value, pat_cnt, busy, done); end
    model_seed = 4'b0001;
    @(negedge clk);
    rst_l = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL post_reset_init: busy=%b want 1", busy); end
    tick();
    n_checks++; if (value !== model_seed || pat_cnt !== 5'd0) begin
      n_fail++; $display("FAIL post_reset_seed: value=%b cnt=%0d want %b 0", value, pat_cnt, model_seed); end
    bist_en = 1'b0;
    repeat (2) tick();
  endtask

`ifdef BIST_MISR_EN
  task automatic test_misr();
    load_seed(4'b0001);
    misr_sel = 1'b1;
    resp_in  = 4'b0110;
    bist_en  = 1'b1;
    num_pat  = 5'd1;
    tick();
    tick();
    n_checks++; if (value !== 4'b0001) begin n_fail++; $display("FAIL misr_init: got %b want 0001", value); end
    tick();
    n_checks++; if (value !== (ref_next(4'b0001) ^ 4'b0110) || value !== 4'b0100 || done !== 1'b1) begin
      n_fail++; $display("FAIL misr_final: value=%b done=%b want 0100 1", value, done); end
    bist_en  = 1'b0;
    misr_sel = 1'b0;
    tick();
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst_l   = 1'b0;
    bist_en = 1'b0;
    seed_ld = 1'b0;
    seed_in = '0;
    num_pat = '0;
`ifdef BIST_MISR_EN
    misr_sel = 1'b0;
    resp_in  = '0;
`endif
    model_seed = 4'b0001;
    test_reset();
    test_short();
    test_max_length();
    test_abort_zero_seed();
    test_zero_count();
    test_random();
    test_reset_mid_run();
`ifdef BIST_MISR_EN
    test_misr();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
